// File: rtl/rgb2hsv_pipe.sv
// Ten-stage RGB-to-HSV converter: min/max/sector, two 7-stage restoring dividers, hue assembly.
// Side-band word, data-enable and bypass flag travel with each pixel at identical latency.
module rgb2hsv_pipe #(
  parameter int PASS_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_de,
  input  logic              bypass,
  input  logic [23:0]       pixel_in,
  input  logic [PASS_W-1:0] pass_in,
  output logic              out_de,
  output logic [23:0]       pixel_out,
  output logic [PASS_W-1:0] pass_thru
);

  localparam logic [1:0] SEC_R = 2'd0;
  localparam logic [1:0] SEC_G = 2'd1;
  localparam logic [1:0] SEC_B = 2'd2;

  // Stage 1 input registers
  logic [23:0]       s1_pix_q;
  logic [PASS_W-1:0] s1_pass_q;
  logic              s1_de_q, s1_byp_q;

  // Index 0 is the stage-2 register; indices 1..7 are divider stages 3..9
  logic [13:0]       rh_q  [0:7];
  logic [6:0]        qh_q  [0:7];
  logic [14:0]       rs_q  [0:7];
  logic [6:0]        qs_q  [0:7];
  logic [7:0]        dl_q  [0:7];
  logic [7:0]        mx_q  [0:7];
  logic [1:0]        sec_q [0:7];
  logic              sgn_q [0:7];
  logic              byp_q [0:7];
  logic              de_q  [0:7];
  logic [23:0]       pix_q [0:7];
  logic [PASS_W-1:0] ps_q  [0:7];

  logic [13:0] rh_d [1:7];
  logic [6:0]  qh_d [1:7];
  logic [14:0] rs_d [1:7];
  logic [6:0]  qs_d [1:7];

  logic [7:0] r_c, g_c, b_c, mx_c, mn_c, pa_c, pb_c, ad_c;
  logic [1:0] sec_c;
  logic       sgn_c;
  logic [15:0] dvh, dvs;
  logic [8:0]  qh9, h_c;
  logic [6:0]  s_c;
  logic [23:0] pix_d;

  assign r_c = s1_pix_q[23:16];
  assign g_c = s1_pix_q[15:8];
  assign b_c = s1_pix_q[7:0];

  always_comb begin
    mx_c = r_c;
    if (g_c > mx_c) mx_c = g_c;
    if (b_c > mx_c) mx_c = b_c;
    mn_c = r_c;
    if (g_c < mn_c) mn_c = g_c;
    if (b_c < mn_c) mn_c = b_c;
    // Ties resolve R over G over B; d = pa - pb for the selected sector
    if (mx_c == r_c) begin
      sec_c = SEC_R; pa_c = g_c; pb_c = b_c;
    end else if (mx_c == g_c) begin
      sec_c = SEC_G; pa_c = b_c; pb_c = r_c;
    end else begin
      sec_c = SEC_B; pa_c = r_c; pb_c = g_c;
    end
    sgn_c = (pa_c < pb_c);
    ad_c  = sgn_c ? (pb_c - pa_c) : (pa_c - pb_c);
  end

  always_comb begin
    dvh = '0;
    dvs = '0;
    for (int k = 1; k < 8; k++) begin
      dvh = {8'b0, dl_q[k-1]} << (7 - k);
      dvs = {8'b0, mx_q[k-1]} << (7 - k);
      if ({2'b0, rh_q[k-1]} >= dvh) begin
        rh_d[k] = 14'({2'b0, rh_q[k-1]} - dvh);
        qh_d[k] = {qh_q[k-1][5:0], 1'b1};
      end else begin
        rh_d[k] = rh_q[k-1];
        qh_d[k] = {qh_q[k-1][5:0], 1'b0};
      end
      if ({1'b0, rs_q[k-1]} >= dvs) begin
        rs_d[k] = 15'({1'b0, rs_q[k-1]} - dvs);
        qs_d[k] = {qs_q[k-1][5:0], 1'b1};
      end else begin
        rs_d[k] = rs_q[k-1];
        qs_d[k] = {qs_q[k-1][5:0], 1'b0};
      end
    end
  end

  always_comb begin
    qh9 = {2'b0, qh_q[7]};
    case (sec_q[7])
      SEC_R:   h_c = sgn_q[7] ? ((qh_q[7] == 7'd0) ? 9'd0 : 9'd360 - qh9) : qh9;
      SEC_G:   h_c = sgn_q[7] ? 9'd120 - qh9 : 9'd120 + qh9;
      default: h_c = sgn_q[7] ? 9'd240 - qh9 : 9'd240 + qh9;
    endcase
    s_c = qs_q[7];
    // Greys and black: quotients are meaningless when delta is zero
    if (dl_q[7] == 8'd0) begin
      h_c = 9'd0;
      s_c = 7'd0;
    end
    pix_d = byp_q[7] ? pix_q[7] : {h_c, s_c, mx_q[7]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_pix_q  <= '0;
      s1_pass_q <= '0;
      s1_de_q   <= 1'b0;
      s1_byp_q  <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        rh_q[k] <= '0; qh_q[k] <= '0; rs_q[k] <= '0; qs_q[k] <= '0;
        dl_q[k] <= '0; mx_q[k] <= '0; sec_q[k] <= '0; sgn_q[k] <= 1'b0;
        byp_q[k] <= 1'b0; de_q[k] <= 1'b0; pix_q[k] <= '0; ps_q[k] <= '0;
      end
      out_de    <= 1'b0;
      pixel_out <= '0;
      pass_thru <= '0;
    end else begin
      s1_pix_q  <= pixel_in;
      s1_pass_q <= pass_in;
      s1_de_q   <= in_de;
      s1_byp_q  <= bypass;

      rh_q[0]  <= {6'b0, ad_c} * 14'd60;
      qh_q[0]  <= '0;
      rs_q[0]  <= {7'b0, mx_c - mn_c} * 15'd127;
      qs_q[0]  <= '0;
      dl_q[0]  <= mx_c - mn_c;
      mx_q[0]  <= mx_c;
      sec_q[0] <= sec_c;
      sgn_q[0] <= sgn_c;
      byp_q[0] <= s1_byp_q;
      de_q[0]  <= s1_de_q;
      pix_q[0] <= s1_pix_q;
      ps_q[0]  <= s1_pass_q;

      for (int k = 1; k < 8; k++) begin
        rh_q[k]  <= rh_d[k];
        qh_q[k]  <= qh_d[k];
        rs_q[k]  <= rs_d[k];
        qs_q[k]  <= qs_d[k];
        dl_q[k]  <= dl_q[k-1];
        mx_q[k]  <= mx_q[k-1];
        sec_q[k] <= sec_q[k-1];
        sgn_q[k] <= sgn_q[k-1];
        byp_q[k] <= byp_q[k-1];
        de_q[k]  <= de_q[k-1];
        pix_q[k] <= pix_q[k-1];
        ps_q[k]  <= ps_q[k-1];
      end

      out_de    <= de_q[7];
      pixel_out <= pix_d;
      pass_thru <= ps_q[7];
    end
  end

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Scoreboard bench for rgb2hsv_pipe: drivers push expected words tagged with their due cycle,
// a negedge monitor pops and compares whenever the DUT reports a valid pixel.
module tb_rgb2hsv_pipe;

  logic        clk = 1'b0;
  logic        rst, in_de, bypass, out_de;
  logic [23:0] pixel_in, pass_in, pixel_out, pass_thru;

  always #5 clk = ~clk;

  rgb2hsv_pipe #(.PASS_W(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_de     (in_de),
    .bypass    (bypass),
    .pixel_in  (pixel_in),
    .pass_in   (pass_in),
    .out_de    (out_de),
    .pixel_out (pixel_out),
    .pass_thru (pass_thru)
  );

  // cyc = number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int zero_lo  = 1;
  int zero_hi  = 1000000;

  typedef struct packed {
    logic [31:0] due;
    logic        byp;
    logic [23:0] pix;
    logic [23:0] pass;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [23:0] hsv_ref(input logic [23:0] rgb);
    int r, g, b, mx, mn, dl, d, base, h, s;
    r = int'(rgb[23:16]);
    g = int'(rgb[15:8]);
    b = int'(rgb[7:0]);
    mx = (r > g) ? r : g;
    mx = (b > mx) ? b : mx;
    mn = (r < g) ? r : g;
    mn = (b < mn) ? b : mn;
    dl = mx - mn;
    if (dl == 0) return {16'd0, 8'(mx)};
    if (mx == r)      begin d = g - b; base = 0;   end
    else if (mx == g) begin d = b - r; base = 120; end
    else              begin d = r - g; base = 240; end
    if (d < 0) h = base - (60 * (-d)) / dl;
    else       h = base + (60 * d) / dl;
    if (h < 0) h = h + 360;
    s = (dl * 127) / mx;
    return {9'(h), 7'(s), 8'(mx)};
  endfunction

  // Input driven in cycle k (after edge k) is expected in cycle k+10
  task automatic drive(input logic de, input logic byp, input logic [23:0] rgb,
                       input logic [23:0] exp_pix);
    @(posedge clk);
    #1;
    in_de    = de;
    bypass   = byp;
    pixel_in = rgb;
    pass_in  = 24'(cyc);
    if (de) exp_q.push_back({32'(cyc + 10), byp, (byp ? rgb : exp_pix), 24'(cyc)});
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_de    = 1'b1;
    bypass   = 1'b0;
    pixel_in = 24'($urandom);
    pass_in  = 24'(cyc);
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > 32'(cyc)) void'(exp_q.pop_back());
    repeat (n) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_de    = 1'b0;
    pixel_in = '0;
    pass_in  = '0;
    zero_lo  = cyc;
    zero_hi  = cyc + 9;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc >= zero_lo && cyc <= zero_hi)
        check("reset_zero", {15'd0, out_de, pixel_out, pass_thru}, 64'd0);
      if (exp_q.size() > 0 && exp_q[0].due == 32'(cyc)) begin
        e = exp_q.pop_front();
        check("out_de", 64'(out_de), 64'd1);
        check("pixel_out", 64'(pixel_out), 64'(e.pix));
        check("pass_thru", 64'(pass_thru), 64'(e.pass));
        if (!e.byp) check("h_range", 64'(pixel_out[23:15] < 9'd360), 64'd1);
      end else begin
        check("idle_de", 64'(out_de), 64'd0);
      end
    end
  end

  logic [23:0] dir_rgb [14] = '{
    24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h808080, 24'h000000, 24'hFFFFFF, 24'hFFFF00,
    24'hFF0080, 24'hFF0A14, 24'hC86464, 24'h64C832, 24'h3264C8, 24'hFF00FF, 24'h00FFFF};
  logic [23:0] dir_exp [14] = '{
    24'h007FFF, 24'h3C7FFF, 24'h787FFF, 24'h000080, 24'h000000, 24'h0000FF, 24'h1E7FFF,
    24'hA57FFF, 24'hB37AFF, 24'h003FC8, 24'h325FC8, 24'h6E5FC8, 24'h967FFF, 24'h5A7FFF};

  initial begin : stimulus
    logic [23:0] rgb;
    logic        de, byp;
    rst = 1'b1; in_de = 1'b0; bypass = 1'b0; pixel_in = '0; pass_in = '0;
    repeat (4) @(posedge clk);
    #1;
    rst     = 1'b0;
    zero_hi = cyc + 9;

    // Directed vectors with hand-computed HSV words, one per clock
    for (int i = 0; i < 14; i++) drive(1'b1, 1'b0, dir_rgb[i], dir_exp[i]);

    // Alternating bypass with pass_in = cycle count
    for (int i = 0; i < 8; i++) begin
      rgb = 24'($urandom);
      drive(1'b1, i[0], rgb, hsv_ref(rgb));
    end

    // de pattern: 3 on, 2 off
    for (int i = 0; i < 20; i++) begin
      rgb = 24'($urandom);
      drive((i % 5) < 3, 1'b0, rgb, hsv_ref(rgb));
    end

    // Reset in the middle of a 20-pixel stream
    for (int i = 0; i < 20; i++) begin
      if (i == 5) do_reset(1);
      else begin
        rgb = 24'($urandom);
        drive(1'b1, 1'b0, rgb, hsv_ref(rgb));
      end
    end

    // Random regression
    for (int i = 0; i < 10000; i++) begin
      rgb = 24'($urandom);
      de  = ($urandom_range(0, 3) != 0);
      byp = ($urandom_range(0, 3) == 0);
      drive(de, byp, rgb, hsv_ref(rgb));
    end

    for (int i = 0; i < 15; i++) drive(1'b0, 1'b0, 24'($urandom), 24'd0);
    @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
